pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch-side program-counter stage for the single-cycle MIPS core; sits upstream of the decoder.
//  Holds the architectural PC and selects the next PC from the decoder's Jump/JumpReg/BranchEq/
//  BranchNeq/InvalidInst outputs and the ALU Zero flag. Adds a 3-state trap sequencer
//  (RUN/TRAP/HALT) with EPC capture, a return-from-trap path and a retired-instruction counter.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  TRAP_VECTOR   32'h0000_0080  PC loaded on a fault (invalid instruction or misaligned jr)
//  CNT_W         32             width of retired-instruction counter
// PORTS
//  clk          in   1      core clock; all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  Stall        in   1      1 = hold PC, EPC, state and counter this cycle
//  Eret         in   1      return-from-trap request (effective only in TRAP)
//  Jump         in   1      from decoder: j/jal
//  JumpReg      in   1      from decoder: jr
//  BranchEq     in   1      from decoder: beq
//  BranchNeq    in   1      from decoder: bne
//  InvalidInst  in   1      from decoder: unrecognised opcode/funct
//  Zero         in   1      ALU result == 0
//  Imm          in   32     sign-extended 16-bit immediate
//  JTarget      in   26     instruction[25:0]
//  RegRs        in   32     rs register read data (jr target)
//  PC           out  32     current instruction address
//  PCPlus4      out  32     PC + 4 (combinational; jal link value)
//  EPC          out  32     address of faulting instruction
//  InTrap       out  1      state == TRAP
//  Halted       out  1      state == HALT
//  RetiredCnt   out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  Reset (rst=1 at edge): PC=RESET_VECTOR, EPC=0, state=RUN, RetiredCnt=0; InTrap=Halted=0.
//  rst overrides Stall, Eret and every decoder input; reset mid-trap or in HALT returns to RUN.
//  Arithmetic mod 2^32: PCPlus4=PC+4; 32'hFFFF_FFFC+4 wraps to 0, no flag.
//  BrTarget=PCPlus4+(Imm<<2) (32-bit, overflow discarded); JTgt={PCPlus4[31:28],JTarget,2'b00}.
//  Fault = InvalidInst | (JumpReg & RegRs[1:0]!=0).
//  Next-PC priority (non-stalled, state RUN or TRAP), highest first:
//   1 Fault -> handled per state below   2 JumpReg -> RegRs   3 Jump -> JTgt
//   4 BranchEq&Zero or BranchNeq&!Zero -> BrTarget   5 else -> PCPlus4
//  Branch not taken -> PCPlus4. Simultaneous Jump+Branch: Jump wins.
//  States (2-bit):
//   RUN : Fault -> EPC<=PC, PC<=TRAP_VECTOR, ->TRAP, count unchanged. Eret ignored (normal next-PC).
//   TRAP: Fault -> double fault: ->HALT, PC and EPC held, count unchanged.
//         Eret (no Fault) -> PC<=EPC+4, ->RUN, count+1. Eret beats jump/branch.
//         else -> normal next-PC, count+1.
//   HALT: PC, EPC, count frozen; all inputs except rst ignored; exits only on reset.
//  Non-faulting instruction in RUN: count+1. Counter wraps at 2^CNT_W.
//  Stall=1: no register changes in any state, even if Fault/Eret asserted that cycle.
//  Latency: next PC visible on PC one cycle after the deciding inputs; PCPlus4, InTrap, Halted
//   are direct decodes of registered state (no extra cycle).
// TESTING
//  1 Reset then 4 plain cycles -> PC 0,4,8,C,10; RetiredCnt=4.
//  2 PC=0x20, BranchEq=1, Zero=1, Imm=-2 -> PC=0x1C; same with Zero=0 -> PC=0x24.
//  3 PC=0x40, JumpReg=1, RegRs=0x102 -> EPC=0x40, PC=0x80, InTrap=1; Eret -> PC=0x44, InTrap=0.
//  4 In TRAP, InvalidInst=1 -> Halted=1; 10 cycles any inputs -> PC, count unchanged; rst -> PC=0.
//  5 PC=0x1000_0000, Jump=1, JTarget=26'h3FF_FFFF, Stall=1 -> PC held; Stall=0 -> PC=0x1FFF_FFFC.
//  6 PC=0xFFFF_FFFC no control -> PC=0; Jump+BranchEq+Zero together -> Jump target taken.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch-side program-counter stage: next-PC select, RUN/TRAP/HALT trap sequencer with EPC
// capture, return-from-trap path and a retired-instruction counter.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Stall,
   input  logic             Eret,
   input  logic             Jump,
   input  logic             JumpReg,
   input  logic             BranchEq,
   input  logic             BranchNeq,
   input  logic             InvalidInst,
   input  logic             Zero,
   input  logic [31:0]      Imm,
   input  logic [25:0]      JTarget,
   input  logic [31:0]      RegRs,
   output logic [31:0]      PC,
   output logic [31:0]      PCPlus4,
   output logic [31:0]      EPC,
   output logic             InTrap,
   output logic             Halted,
   output logic [CNT_W-1:0] RetiredCnt
);

   typedef enum logic [1:0] {StRun, StTrap, StHalt} state_e;

   state_e            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       epc_q, epc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [31:0]       pc_plus4;
   logic [31:0]       br_target;
   logic [31:0]       j_target;
   logic [31:0]       normal_pc;
   logic              fault;
   logic              br_taken;

   assign pc_plus4  = pc_q + 32'd4;
   assign br_target = pc_plus4 + (Imm << 2);
   assign j_target  = {pc_plus4[31:28], JTarget, 2'b00};
   // A jr to a non-word-aligned address is treated like an illegal instruction.
   assign fault     = InvalidInst | (JumpReg & (RegRs[1:0] != 2'b00));
   assign br_taken  = (BranchEq & Zero) | (BranchNeq & ~Zero);

   always_comb begin
      normal_pc = pc_plus4;
      if (JumpReg) begin
         normal_pc = RegRs;
      end else if (Jump) begin
         normal_pc = j_target;
      end else if (br_taken) begin
         normal_pc = br_target;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epc_d   = epc_q;
      cnt_d   = cnt_q;
      if (!Stall) begin
         case (state_q)
            StRun: begin
               if (fault) begin
                  epc_d   = pc_q;
                  pc_d    = TRAP_VECTOR;
                  state_d = StTrap;
               end else begin
                  pc_d  = normal_pc;
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            StTrap: begin
               if (fault) begin
                  // Double fault: freeze everything until reset.
                  state_d = StHalt;
               end else if (Eret) begin
                  pc_d    = epc_q + 32'd4;
                  state_d = StRun;
                  cnt_d   = cnt_q + CNT_W'(1);
               end else begin
                  pc_d  = normal_pc;
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
         pc_q    <= RESET_VECTOR;
         epc_q   <= 32'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign PC         = pc_q;
   assign PCPlus4    = pc_plus4;
   assign EPC        = epc_q;
   assign InTrap     = (state_q == StTrap);
   assign Halted     = (state_q == StHalt);
   assign RetiredCnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer; each row drives one cycle of inputs and
// states the register values expected just after the following rising edge.
module tb_pc_sequencer;

   localparam logic [8:0] RST = 9'h100;
   localparam logic [8:0] STL = 9'h080;
   localparam logic [8:0] ERT = 9'h040;
   localparam logic [8:0] JMP = 9'h020;
   localparam logic [8:0] JR  = 9'h010;
   localparam logic [8:0] BEQ = 9'h008;
   localparam logic [8:0] BNE = 9'h004;
   localparam logic [8:0] INV = 9'h002;
   localparam logic [8:0] ZR  = 9'h001;

   typedef struct {
      logic [8:0]  ctl;
      logic [31:0] imm;
      logic [25:0] jt;
      logic [31:0] rs;
      logic [31:0] pc;
      logic [31:0] epc;
      logic        trap;
      logic        halt;
      logic [31:0] cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, Stall, Eret, Jump, JumpReg, BranchEq, BranchNeq, InvalidInst, Zero;
   logic [31:0] Imm, RegRs;
   logic [25:0] JTarget;
   logic [31:0] PC, PCPlus4, EPC, RetiredCnt;
   logic        InTrap, Halted;

   int total = 0;
   int bad   = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   pc_sequencer #(
      .RESET_VECTOR (32'h0000_0000),
      .TRAP_VECTOR  (32'h0000_0080),
      .CNT_W        (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .Stall       (Stall),
      .Eret        (Eret),
      .Jump        (Jump),
      .JumpReg     (JumpReg),
      .BranchEq    (BranchEq),
      .BranchNeq   (BranchNeq),
      .InvalidInst (InvalidInst),
      .Zero        (Zero),
      .Imm         (Imm),
      .JTarget     (JTarget),
      .RegRs       (RegRs),
      .PC          (PC),
      .PCPlus4     (PCPlus4),
      .EPC         (EPC),
      .InTrap      (InTrap),
      .Halted      (Halted),
      .RetiredCnt  (RetiredCnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [8:0] ctl, input logic [31:0] imm, input logic [25:0] jt,
                        input logic [31:0] rs);
      {rst, Stall, Eret, Jump, JumpReg, BranchEq, BranchNeq, InvalidInst, Zero} = ctl;
      Imm     = imm;
      JTarget = jt;
      RegRs   = rs;
   endtask

   task automatic add(input logic [8:0] ctl, input logic [31:0] imm, input logic [25:0] jt,
                      input logic [31:0] rs, input logic [31:0] pc, input logic [31:0] epc,
                      input logic trap, input logic halt, input logic [31:0] cnt);
      vec_t v;
      v.ctl = ctl; v.imm = imm; v.jt = jt; v.rs = rs;
      v.pc = pc; v.epc = epc; v.trap = trap; v.halt = halt; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         drive(vecs[i].ctl, vecs[i].imm, vecs[i].jt, vecs[i].rs);
         @(posedge clk);
         #1;
         check($sformatf("row%0d pc", i), PC, vecs[i].pc);
         check($sformatf("row%0d pcplus4", i), PCPlus4, vecs[i].pc + 32'd4);
         check($sformatf("row%0d epc", i), EPC, vecs[i].epc);
         check($sformatf("row%0d intrap", i), {31'd0, InTrap}, {31'd0, vecs[i].trap});
         check($sformatf("row%0d halted", i), {31'd0, Halted}, {31'd0, vecs[i].halt});
         check($sformatf("row%0d cnt", i), RetiredCnt, vecs[i].cnt);
      end
   endtask

   initial begin
      drive(RST, 32'd0, 26'd0, 32'd0);
      //   ctl          imm            jtarget      regrs          pc             epc    trp hlt cnt
      add(RST,          32'd0,         26'd0,       32'd0,         32'h0,         32'h0,  0, 0, 0);  // 0
      add(9'd0,         32'd0,         26'd0,       32'd0,         32'h4,         32'h0,  0, 0, 1);
      add(9'd0,         32'd0,         26'd0,       32'd0,         32'h8,         32'h0,  0, 0, 2);
      add(9'd0,         32'd0,         26'd0,       32'd0,         32'hC,         32'h0,  0, 0, 3);
      add(9'd0,         32'd0,         26'd0,       32'd0,         32'h10,        32'h0,  0, 0, 4);
      add(JR,           32'd0,         26'd0,       32'h20,        32'h20,        32'h0,  0, 0, 5);  // 5
      add(BEQ|ZR,       32'hFFFF_FFFE, 26'd0,       32'd0,         32'h1C,        32'h0,  0, 0, 6);
      add(JR,           32'd0,         26'd0,       32'h20,        32'h20,        32'h0,  0, 0, 7);
      add(BEQ,          32'hFFFF_FFFE, 26'd0,       32'd0,         32'h24,        32'h0,  0, 0, 8);
      add(BNE,          32'd3,         26'd0,       32'd0,         32'h34,        32'h0,  0, 0, 9);
      add(BNE|ZR,       32'd3,         26'd0,       32'd0,         32'h38,        32'h0,  0, 0, 10); // 10
      add(JR,           32'd0,         26'd0,       32'h40,        32'h40,        32'h0,  0, 0, 11);
      add(JR,           32'd0,         26'd0,       32'h102,       32'h80,        32'h40, 1, 0, 11);
      add(ERT|STL,      32'd0,         26'd0,       32'd0,         32'h80,        32'h40, 1, 0, 11);
      add(9'd0,         32'd0,         26'd0,       32'd0,         32'h84,        32'h40, 1, 0, 12);
      add(ERT|JMP,      32'd0,         26'h100,     32'd0,         32'h44,        32'h40, 0, 0, 13); // 15
      add(ERT,          32'd0,         26'd0,       32'd0,         32'h48,        32'h40, 0, 0, 14);
      add(INV,          32'd0,         26'd0,       32'd0,         32'h80,        32'h48, 1, 0, 14);
      add(INV,          32'd0,         26'd0,       32'd0,         32'h80,        32'h48, 0, 1, 14);
      add(RST|STL|INV,  32'd0,         26'd0,       32'd0,         32'h0,         32'h0,  0, 0, 0);
      add(STL|INV,      32'd0,         26'd0,       32'd0,         32'h0,         32'h0,  0, 0, 0);  // 20
      add(JR,           32'd0,         26'd0,       32'h1000_0000, 32'h1000_0000, 32'h0,  0, 0, 1);
      add(STL|JMP,      32'd0,         26'h3FF_FFFF, 32'd0,        32'h1000_0000, 32'h0,  0, 0, 1);
      add(JMP,          32'd0,         26'h3FF_FFFF, 32'd0,        32'h1FFF_FFFC, 32'h0,  0, 0, 2);
      add(JR,           32'd0,         26'd0,       32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,  0, 0, 3);
      add(9'd0,         32'd0,         26'd0,       32'd0,         32'h0,         32'h0,  0, 0, 4);  // 25
      add(JMP|BEQ|ZR,   32'd5,         26'h10,      32'd0,         32'h40,        32'h0,  0, 0, 5);
      add(JR,           32'd0,         26'd0,       32'h101,       32'h80,        32'h40, 1, 0, 5);
      add(RST,          32'd0,         26'd0,       32'd0,         32'h0,         32'h0,  0, 0, 0);

      run_rows(0, 18);

      // Halted: ten cycles of arbitrary non-reset inputs must change nothing.
      for (int k = 0; k < 10; k++) begin
         drive({1'b0, 8'($urandom)}, $urandom, 26'($urandom), $urandom);
         @(posedge clk);
         #1;
         check($sformatf("halt%0d pc", k), PC, 32'h80);
         check($sformatf("halt%0d epc", k), EPC, 32'h48);
         check($sformatf("halt%0d cnt", k), RetiredCnt, 32'd14);
         check($sformatf("halt%0d halted", k), {31'd0, Halted}, 32'd1);
      end

      run_rows(19, vecs.size() - 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
